// File: rtl/u2_to_zm_serial_pkg.sv
// Shared types for the serial U2/ZM converter family.
// State encoding and o_status bit positions.
package u2_to_zm_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH,
    DONE
  } state_e;

  localparam int STAT_ERR    = 0;
  localparam int STAT_SIGN   = 1;
  localparam int STAT_PARITY = 2;
  localparam int STAT_ONES   = 3;

endpackage

// File: rtl/u2_to_zm_serial_if.sv
// Operand/result handshake bundle for the serial converter.
// master drives operands and result-ready; slave is the block.
interface u2_to_zm_serial_if #(
  parameter int m = 4
);
  logic         i_valid;
  logic         o_ready;
  logic [m-1:0] i_argA;
  logic         o_valid;
  logic         i_ready;
  logic [m-1:0] o_result;
  logic [3:0]   o_status;

  modport master (
    output i_valid, i_argA, i_ready,
    input  o_ready, o_valid, o_result, o_status
  );

  modport slave (
    input  i_valid, i_argA, i_ready,
    output o_ready, o_valid, o_result, o_status
  );
endinterface

// File: rtl/zm_status_flags.sv
// Status flags for a sign-magnitude result.
// An error forces every other flag to zero.
module zm_status_flags
  import u2_to_zm_serial_pkg::*;
#(
  parameter int m = 4
) (
  input  logic [m-1:0] i_result,
  input  logic         i_err,
  output logic [3:0]   o_status
);

  // Flag decode from the final result
  always_comb begin
    o_status = '0;
    if (i_err) begin
      o_status[STAT_ERR] = 1'b1;
    end else begin
      o_status[STAT_SIGN]   = i_result[m-1];
      o_status[STAT_PARITY] = ~^i_result;
      o_status[STAT_ONES]   = &i_result;
    end
  end

endmodule

// File: rtl/u2_to_zm_serial.sv
// Bit-serial two's complement to sign-magnitude converter.
// Magnitude is negated LSB first using a seen-one flag.
module u2_to_zm_serial
  import u2_to_zm_serial_pkg::*;
#(
  parameter int m = 4,
  parameter int n = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  u2_to_zm_serial_if.slave     bus
);

  localparam int CW = $clog2(m);

  if (m < 2 || n < 0) begin : g_bad_cfg
    $error("u2_to_zm_serial: m must be >= 2");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;
  logic [m-1:0]  arg_q, arg_d;
  logic [m-2:0]  mag_q, mag_d;
  logic [m-1:0]  res_q, res_d;
  logic [3:0]    stat_q, stat_d;

  logic          in_bit;
  logic          out_bit;
  logic          err;
  logic [m-1:0]  fin_res;
  logic [3:0]    fin_stat;

  assign in_bit  = arg_q[cnt_q];
  assign out_bit = (arg_q[m-1] & seen_q) ? ~in_bit : in_bit;
  assign err     = arg_q[m-1] & ~|arg_q[m-2:0];
  assign fin_res = err ? '0 : {arg_q[m-1], mag_q};

  zm_status_flags #(
    .m(m)
  ) u_flags (
    .i_result (fin_res),
    .i_err    (err),
    .o_status (fin_stat)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    arg_d   = arg_q;
    mag_d   = mag_q;
    res_d   = res_q;
    stat_d  = stat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          arg_d   = bus.i_argA;
          cnt_d   = '0;
          seen_d  = 1'b0;
          mag_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        mag_d[cnt_q] = out_bit;
        seen_d       = seen_q | in_bit;
        if (cnt_q == CW'(m-2)) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH: begin
        res_d   = fin_res;
        stat_d  = fin_stat;
        state_d = DONE;
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      arg_q   <= '0;
      mag_q   <= '0;
      res_q   <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      arg_q   <= arg_d;
      mag_q   <= mag_d;
      res_q   <= res_d;
      stat_q  <= stat_d;
    end
  end

  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_result = res_q;
  assign bus.o_status = stat_q;

endmodule

// File: tb/tb_u2_to_zm_serial.sv
// Directed and random checks of the serial U2->ZM converter.
// Vectors, backpressure, mid-operation reset, random stream.
module tb_u2_to_zm_serial;

  localparam int M = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  u2_to_zm_serial_if #(.m(M)) bus ();

  u2_to_zm_serial #(
    .m(M),
    .n(2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] arg;
    logic [3:0] res;
    logic [3:0] st;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_zm(input logic [3:0] a);
    logic [3:0] ng;
    if (a == 4'b1000) return 4'b0000;
    if (a[3]) begin
      ng = -a;
      return {1'b1, ng[2:0]};
    end
    return a;
  endfunction

  function automatic logic [3:0] ref_st(input logic [3:0] a);
    logic [3:0] r;
    int ones;
    if (a == 4'b1000) return 4'b0001;
    r = ref_zm(a);
    ones = 0;
    for (int i = 0; i < 4; i++) ones += int'(r[i]);
    return {(ones == 4), (ones % 2 == 0), r[3], 1'b0};
  endfunction

  task automatic run_op(input logic [3:0] a, input logic [3:0] er,
                        input logic [3:0] es, input int stall,
                        input string nm);
    @(negedge clk);
    chk({nm, "_rdy"}, {3'b0, bus.o_ready}, 4'd1);
    bus.i_valid = 1'b1;
    bus.i_argA  = a;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_argA  = ~a;
    for (int k = 1; k <= M; k++) begin
      @(posedge clk);
      #1;
      chk({nm, "_vld"}, {3'b0, bus.o_valid}, {3'b0, k == M});
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      bus.i_valid = (s == 1);
      bus.i_argA  = 4'b0111;
      chk({nm, "_bp_rdy"}, {3'b0, bus.o_ready}, 4'd0);
      @(posedge clk);
      #1;
      chk({nm, "_bp_vld"}, {3'b0, bus.o_valid}, 4'd1);
      chk({nm, "_bp_res"}, bus.o_result, er);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk({nm, "_res"}, bus.o_result, er);
    chk({nm, "_st"}, bus.o_status, es);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    chk({nm, "_idle_vld"}, {3'b0, bus.o_valid}, 4'd0);
    chk({nm, "_idle_rdy"}, {3'b0, bus.o_ready}, 4'd1);
  endtask

  initial begin
    logic [3:0] a;
    int wait_cnt;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_argA  = '0;
    bus.i_ready = 1'b0;

    vecs[0]  = '{4'b0011, 4'b0011, 4'b0100};
    vecs[1]  = '{4'b1101, 4'b1011, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b1001, 4'b0110};
    vecs[3]  = '{4'b1001, 4'b1111, 4'b1110};
    vecs[4]  = '{4'b1000, 4'b0000, 4'b0001};
    vecs[5]  = '{4'b0000, 4'b0000, 4'b0100};
    vecs[6]  = '{4'b0111, 4'b0111, 4'b0000};
    vecs[7]  = '{4'b0101, 4'b0101, 4'b0100};
    vecs[8]  = '{4'b1110, 4'b1010, 4'b0110};
    vecs[9]  = '{4'b0001, 4'b0001, 4'b0000};
    vecs[10] = '{4'b1100, 4'b1100, 4'b0110};
    vecs[11] = '{4'b1010, 4'b1110, 4'b0010};

    #2;
    chk("rst_vld", {3'b0, bus.o_valid}, 4'd0);
    chk("rst_rdy", {3'b0, bus.o_ready}, 4'd1);
    chk("rst_res", bus.o_result, 4'd0);
    chk("rst_st", bus.o_status, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].arg, vecs[i].res, vecs[i].st, 0,
             $sformatf("vec%0d", i));
    end

    run_op(4'b1101, 4'b1011, 4'b0010, 3, "bp");
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_no_accept", {3'b0, bus.o_ready}, 4'd1);
    end

    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_argA  = 4'b1101;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {3'b0, bus.o_valid}, 4'd0);
    chk("mid_rst_rdy", {3'b0, bus.o_ready}, 4'd1);
    chk("mid_rst_res", bus.o_result, 4'd0);
    chk("mid_rst_st", bus.o_status, 4'd0);
    bus.i_valid = 1'b1;
    bus.i_argA  = 4'b0011;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("mid_rst_quiet", {2'b0, bus.o_valid, bus.o_ready}, 4'd1);
    end
    run_op(4'b0011, 4'b0011, 4'b0100, 0, "post_rst");

    for (int t = 0; t < 1000; t++) begin
      a = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_argA  = a;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      wait_cnt = 0;
      while (!bus.o_valid && wait_cnt < 20) begin
        @(negedge clk);
        bus.i_valid = 1'($urandom_range(0, 1));
        bus.i_argA  = 4'($urandom_range(0, 15));
        @(posedge clk);
        #1;
        wait_cnt++;
      end
      if (!bus.o_valid) begin
        checks++;
        errors++;
        $display("FAIL rnd_timeout got no o_valid want o_valid op %0d", t);
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bus.i_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      bus.i_valid = 1'b0;
      chk($sformatf("rnd_res_%b", a), bus.o_result, ref_zm(a));
      chk($sformatf("rnd_st_%b", a), bus.o_status, ref_st(a));
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.i_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
